// File: rtl/spr_scan_reader.sv
// Scan reader for the 32x32 special-purpose register file: walks a wrapping index range
// on the RAM read port and streams each word with its index over valid/ready.
module spr_scan_reader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] Sa,
   input  logic [DATA_W-1:0] Sout,
   input  logic              Sw,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [ADDR_W-1:0] m_addr,
   output logic              m_last,
   output logic              busy,
   output logic              done,
   output logic              dirty
);

   localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W:0]   rem;
   logic              start_ok;
   logic              empty_start;
   logic              hshake;

   function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
      return (c > DEPTH_W) ? DEPTH_W : c;
   endfunction

   assign start_ok    = (state == IDLE) && start;
   assign empty_start = start_ok && (count == '0);
   assign hshake      = (state == SEND) && m_valid && m_ready;
   assign Sa          = idx;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_ok && !empty_start) state_nxt = FETCH;
         FETCH:   state_nxt = SEND;
         SEND:    if (hshake) state_nxt = m_last ? IDLE : FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx     <= '0;
         rem     <= '0;
         m_data  <= '0;
         m_addr  <= '0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         done    <= 1'b0;
         dirty   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start_ok) begin
            idx   <= first;
            rem   <= clamp_count(count);
            dirty <= 1'b0;
            done  <= empty_start;
         end else if (busy && Sw) begin
            dirty <= 1'b1;
         end
         // FETCH: Sa has been stable for a full cycle, so Sout is the word at idx
         if (state == FETCH) begin
            m_data  <= Sout;
            m_addr  <= idx;
            m_last  <= (rem == REM_ONE);
            m_valid <= 1'b1;
         end
         // SEND: the final word leaves idx pointing at itself
         if (hshake) begin
            m_valid <= 1'b0;
            rem     <= rem - REM_ONE;
            if (m_last) done <= 1'b1;
            else        idx  <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spr_scan_reader.sv
// Directed bench for spr_scan_reader with a behavioural register-file read port.
module tb_spr_scan_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [4:0]  first;
   logic [5:0]  count;
   logic [4:0]  Sa;
   logic [31:0] Sout;
   logic        Sw;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic [4:0]  m_addr;
   logic        m_last;
   logic        busy;
   logic        done;
   logic        dirty;

   logic [31:0] ram [32];
   int          errors = 0;
   int          checks = 0;

   logic [4:0]  q_addr [64];
   logic [31:0] q_data [64];
   logic        q_last [64];
   int          nwords;
   int          first_vld_cyc;
   int          done_cyc;
   bit          timed_out;

   always #5 clk = ~clk;

   assign Sout = ram[Sa];

   spr_scan_reader #(.ADDR_W(5), .DATA_W(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .first   (first),
      .count   (count),
      .Sa      (Sa),
      .Sout    (Sout),
      .Sw      (Sw),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_addr  (m_addr),
      .m_last  (m_last),
      .busy    (busy),
      .done    (done),
      .dirty   (dirty)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_scan(input logic [4:0] f, input logic [5:0] c);
      start = 1'b1;
      first = f;
      count = c;
      tick();
      start = 1'b0;
   endtask

   task automatic record_word();
      if (nwords < 64) begin
         q_addr[nwords] = m_addr;
         q_data[nwords] = m_data;
         q_last[nwords] = m_last;
      end
      nwords++;
   endtask

   // Collects words until done; optionally pulses Sw or a stray start when a given address is on the bus.
   task automatic collect(input int max_cyc, input int sw_addr, input int restart_addr);
      int cyc;
      bit sw_sent;
      bit rs_sent;
      cyc = 0; sw_sent = 0; rs_sent = 0;
      nwords = 0; first_vld_cyc = -1; done_cyc = -1; timed_out = 1;
      while (cyc < max_cyc) begin
         if (m_valid && sw_addr >= 0 && m_addr == 5'(sw_addr) && !sw_sent) begin
            Sw = 1'b1; sw_sent = 1;
         end
         if (m_valid && restart_addr >= 0 && m_addr == 5'(restart_addr) && !rs_sent) begin
            start = 1'b1; first = 5'd20; count = 6'd1; rs_sent = 1;
         end
         if (m_valid && m_ready) begin
            if (nwords == 0) first_vld_cyc = cyc;
            record_word();
         end
         tick();
         cyc++;
         Sw = 1'b0;
         start = 1'b0;
         if (done) begin
            done_cyc = cyc;
            timed_out = 0;
            break;
         end
      end
   endtask

   // Words expected: index (f+k) mod 32, data A5000000|index, last only on the final word.
   function automatic int count_bad_words(input int f, input int n);
      int bad;
      logic [4:0] a;
      bad = 0;
      for (int k = 0; k < n; k++) begin
         a = 5'(f + k);
         if (q_addr[k] !== a || q_data[k] !== (32'hA500_0000 | {27'd0, a}) ||
             q_last[k] !== 1'(k == n - 1))
            bad++;
      end
      return bad;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; first = '0; count = '0; Sw = 1'b0; m_ready = 1'b0;
      repeat (3) tick();
      checks++;
      if ({Sa, m_data, m_addr, m_valid, m_last, busy, done, dirty} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: Sa=%0d data=%h addr=%0d v=%0b last=%0b busy=%0b done=%0b dirty=%0b, want all 0",
                  Sa, m_data, m_addr, m_valid, m_last, busy, done, dirty);
      end
      rst_n = 1'b1;
      tick();
      Sw = 1'b1;
      tick();
      Sw = 1'b0;
      tick();
      checks++;
      if (dirty !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_sw: dirty=%0b busy=%0b, want 0 0", dirty, busy);
      end
   endtask

   task automatic test_full_scan();
      m_ready = 1'b1;
      start_scan(5'd0, 6'd32);
      collect(200, -1, -1);
      checks++;
      if (timed_out) begin errors++; $display("FAIL full_timeout: done=%0b, want done within budget", done); end
      checks++;
      if (nwords !== 32) begin errors++; $display("FAIL full_count: got %0d words, want 32", nwords); end
      checks++;
      if (count_bad_words(0, 32) !== 0) begin
         errors++; $display("FAIL full_words: %0d bad words, want 0", count_bad_words(0, 32));
      end
      // First m_valid cycle through the done cycle inclusive: 32 words at 2 cycles each.
      checks++;
      if (done_cyc - first_vld_cyc + 1 !== 64) begin
         errors++; $display("FAIL full_span: %0d cycles, want 64", done_cyc - first_vld_cyc + 1);
      end
      checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
         errors++; $display("FAIL full_end_state: busy=%0b valid=%0b, want 0 0", busy, m_valid);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse: done=%0b one cycle later, want 0", done); end
   endtask

   task automatic test_wrap();
      m_ready = 1'b1;
      start_scan(5'd30, 6'd4);
      collect(50, -1, -1);
      checks++;
      if (timed_out || nwords !== 4) begin
         errors++; $display("FAIL wrap_count: got %0d words timeout=%0b, want 4 0", nwords, timed_out);
      end
      checks++;
      if (count_bad_words(30, 4) !== 0 || q_addr[3] !== 5'd1) begin
         errors++; $display("FAIL wrap_words: bad=%0d last_addr=%0d, want 0 1", count_bad_words(30, 4), q_addr[3]);
      end
      checks++;
      if (dirty !== 1'b0) begin errors++; $display("FAIL wrap_dirty: dirty=%0b, want 0", dirty); end
      tick();
   endtask

   task automatic test_backpressure();
      int cyc;
      bit stalled;
      m_ready = 1'b1;
      start_scan(5'd0, 6'd5);
      nwords = 0; cyc = 0; stalled = 0; timed_out = 1;
      while (cyc < 100) begin
         if (m_valid && m_addr == 5'd2 && !stalled) begin
            m_ready = 1'b0;
            stalled = 1;
            for (int s = 0; s < 5; s++) begin
               tick();
               cyc++;
               checks++;
               if ({m_valid, m_addr, m_data} !== {1'b1, 5'd2, 32'hA500_0002}) begin
                  errors++;
                  $display("FAIL bp_hold[%0d]: v=%0b addr=%0d data=%h, want 1 2 a5000002", s, m_valid, m_addr, m_data);
               end
            end
            m_ready = 1'b1;
         end
         if (m_valid && m_ready) record_word();
         tick();
         cyc++;
         if (done) begin timed_out = 0; break; end
      end
      checks++;
      if (timed_out || nwords !== 5) begin
         errors++; $display("FAIL bp_count: got %0d words timeout=%0b, want 5 0", nwords, timed_out);
      end
      checks++;
      if (count_bad_words(0, 5) !== 0) begin
         errors++; $display("FAIL bp_words: %0d bad words, want 0", count_bad_words(0, 5));
      end
      tick();
   endtask

   task automatic test_empty_and_clamp();
      bit activity;
      m_ready = 1'b1;
      start_scan(5'd3, 6'd0);
      checks++;
      if ({done, busy, m_valid} !== 3'b100) begin
         errors++; $display("FAIL empty_start: done=%0b busy=%0b v=%0b, want 1 0 0", done, busy, m_valid);
      end
      activity = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done || busy || m_valid) activity = 1;
      end
      checks++;
      if (activity !== 1'b0) begin errors++; $display("FAIL empty_after: activity=%0b, want 0", activity); end
      start_scan(5'd7, 6'd40);
      collect(200, -1, -1);
      checks++;
      if (timed_out || nwords !== 32) begin
         errors++; $display("FAIL clamp_count: got %0d words timeout=%0b, want 32 0", nwords, timed_out);
      end
      checks++;
      if (count_bad_words(7, 32) !== 0) begin
         errors++; $display("FAIL clamp_words: %0d bad words, want 0", count_bad_words(7, 32));
      end
      tick();
   endtask

   task automatic test_dirty_and_restart();
      m_ready = 1'b1;
      start_scan(5'd0, 6'd8);
      collect(100, 3, 5);
      checks++;
      if (timed_out || nwords !== 8) begin
         errors++; $display("FAIL restart_count: got %0d words timeout=%0b, want 8 0", nwords, timed_out);
      end
      checks++;
      if (count_bad_words(0, 8) !== 0) begin
         errors++; $display("FAIL restart_words: %0d bad words, want 0", count_bad_words(0, 8));
      end
      checks++;
      if (dirty !== 1'b1) begin errors++; $display("FAIL dirty_set: dirty=%0b, want 1", dirty); end
      repeat (3) tick();
      checks++;
      if (dirty !== 1'b1) begin errors++; $display("FAIL dirty_sticky: dirty=%0b, want 1", dirty); end
      start_scan(5'd10, 6'd1);
      checks++;
      if (dirty !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL dirty_clear: dirty=%0b busy=%0b, want 0 1", dirty, busy);
      end
      collect(20, -1, -1);
      tick();
   endtask

   task automatic test_reset_mid_scan();
      m_ready = 1'b0;
      start_scan(5'd0, 6'd4);
      tick();
      checks++;
      if (m_valid !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_send: v=%0b busy=%0b, want 1 1", m_valid, busy);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if ({Sa, m_data, m_addr, m_valid, m_last, busy, done, dirty} !== '0) begin
         errors++;
         $display("FAIL mid_reset: Sa=%0d data=%h addr=%0d v=%0b last=%0b busy=%0b done=%0b dirty=%0b, want all 0",
                  Sa, m_data, m_addr, m_valid, m_last, busy, done, dirty);
      end
      rst_n = 1'b1;
      tick();
      m_ready = 1'b1;
      start_scan(5'd5, 6'd1);
      collect(20, -1, -1);
      checks++;
      if (timed_out || nwords !== 1) begin
         errors++; $display("FAIL post_reset_count: got %0d words timeout=%0b, want 1 0", nwords, timed_out);
      end
      checks++;
      if (count_bad_words(5, 1) !== 0) begin
         errors++; $display("FAIL post_reset_word: addr=%0d last=%0b data=%h, want 5 1 a5000005",
                            q_addr[0], q_last[0], q_data[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 32'hA500_0000 | 32'(i);
      test_reset();
      test_full_scan();
      test_wrap();
      test_backpressure();
      test_empty_and_clamp();
      test_dirty_and_restart();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
